// File: rtl/target_power_sequencer_if.sv
// Control and status bundle between the register block and the target power sequencer.
interface target_power_sequencer_if;
  logic       pwr_on_req;
  logic       fault_i;
  logic       fault_clear;
  logic       target_npower;
  logic       target_highz;
  logic [2:0] pwr_state;
  logic       fault_latched;

  modport master (
    output pwr_on_req, fault_i, fault_clear,
    input  target_npower, target_highz, pwr_state, fault_latched
  );

  modport slave (
    input  pwr_on_req, fault_i, fault_clear,
    output target_npower, target_highz, pwr_state, fault_latched
  );
endinterface

// File: rtl/target_power_sequencer.sv
// Target supply sequencer: optional PWM soft-start, IO settle hold, overcurrent latch.
// Soft-start ramp is built only when TARGET_PWR_SOFTSTART_EN is defined.
//
// state  | meaning
// OFF    | supply off, IO tri-stated, waiting for a power request
// RAMP   | soft-start: 16 duty steps, low time grows 1/16 .. 16/16 per step
// SETTLE | supply fully on, IO still tri-stated while the target settles
// ON     | supply on, IO released
// FAULT  | overcurrent latched, supply off until cleared with the fault gone
module target_power_sequencer #(
  parameter int unsigned STEP_PERIODS  = 4,
  parameter int unsigned SETTLE_CYCLES = 4096
) (
  input  logic                     clk_usb,
  input  logic                     reset_i,
  target_power_sequencer_if.slave  bus
);

`ifdef TARGET_PWR_SOFTSTART_EN
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RAMP   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ON     = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd2,
    ST_ON     = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;
`endif

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);

  if (STEP_PERIODS < 1 || STEP_PERIODS > 255 ||
      SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_param_out_of_range
  end

  state_t      state;
  logic        npower;
  logic        highz;
  logic        latched;
  logic        sync1;
  logic        flt;
  logic [15:0] settle_cnt;
  logic        active;

  always_comb begin
    active = 1'b0;
    case (state)
`ifdef TARGET_PWR_SOFTSTART_EN
      ST_RAMP,
`endif
      ST_SETTLE, ST_ON: active = 1'b1;
      default:          active = 1'b0;
    endcase
  end

`ifdef TARGET_PWR_SOFTSTART_EN
  localparam logic [7:0] STEP_M1 = 8'(STEP_PERIODS - 1);

  logic [3:0] pwm_pos;
  logic [3:0] step;
  logic [7:0] period_left;
  logic       pos_wrap;
  logic       step_done;
  logic       ramp_done;
  logic [3:0] nxt_pos;
  logic [3:0] nxt_step;
  logic [7:0] nxt_period;
  logic       nxt_low;

  // Position of the next RAMP cycle; the drive is registered one cycle ahead.
  always_comb begin
    pos_wrap   = (pwm_pos == 4'd15);
    step_done  = pos_wrap && (period_left == 8'd0);
    ramp_done  = step_done && (step == 4'd15);
    nxt_pos    = pwm_pos + 4'd1;
    nxt_step   = step_done ? step + 4'd1 : step;
    nxt_period = period_left;
    if (pos_wrap) nxt_period = (period_left == 8'd0) ? STEP_M1 : period_left - 8'd1;
    nxt_low    = (nxt_pos <= nxt_step);
  end
`endif

  always_ff @(posedge clk_usb or posedge reset_i) begin
    if (reset_i) begin
      state      <= ST_OFF;
      npower     <= 1'b1;
      highz      <= 1'b1;
      latched    <= 1'b0;
      sync1      <= 1'b0;
      flt        <= 1'b0;
      settle_cnt <= 16'd0;
`ifdef TARGET_PWR_SOFTSTART_EN
      pwm_pos     <= 4'd0;
      step        <= 4'd0;
      period_left <= 8'd0;
`endif
    end else begin
      sync1 <= bus.fault_i;
      flt   <= sync1;
      if (active && flt) begin
        state      <= ST_FAULT;
        npower     <= 1'b1;
        highz      <= 1'b1;
        latched    <= 1'b1;
        settle_cnt <= 16'd0;
`ifdef TARGET_PWR_SOFTSTART_EN
        pwm_pos     <= 4'd0;
        step        <= 4'd0;
        period_left <= 8'd0;
`endif
      end else if ((active && !bus.pwr_on_req) ||
                   (state == ST_FAULT && bus.fault_clear && !flt)) begin
        state      <= ST_OFF;
        npower     <= 1'b1;
        highz      <= 1'b1;
        latched    <= 1'b0;
        settle_cnt <= 16'd0;
`ifdef TARGET_PWR_SOFTSTART_EN
        pwm_pos     <= 4'd0;
        step        <= 4'd0;
        period_left <= 8'd0;
`endif
      end else begin
        case (state)
          ST_OFF: begin
            if (bus.pwr_on_req && !flt) begin
              npower <= 1'b0;
`ifdef TARGET_PWR_SOFTSTART_EN
              state       <= ST_RAMP;
              pwm_pos     <= 4'd0;
              step        <= 4'd0;
              period_left <= STEP_M1;
`else
              state      <= ST_SETTLE;
              settle_cnt <= SETTLE_LOAD;
`endif
            end
          end
`ifdef TARGET_PWR_SOFTSTART_EN
          ST_RAMP: begin
            if (ramp_done) begin
              state       <= ST_SETTLE;
              npower      <= 1'b0;
              settle_cnt  <= SETTLE_LOAD;
              pwm_pos     <= 4'd0;
              step        <= 4'd0;
              period_left <= 8'd0;
            end else begin
              pwm_pos     <= nxt_pos;
              step        <= nxt_step;
              period_left <= nxt_period;
              npower      <= !nxt_low;
            end
          end
`endif
          ST_SETTLE: begin
            if (settle_cnt == 16'd1) begin
              state      <= ST_ON;
              highz      <= 1'b0;
              settle_cnt <= 16'd0;
            end else begin
              settle_cnt <= settle_cnt - 16'd1;
            end
          end
          ST_ON:    state <= ST_ON;
          ST_FAULT: state <= ST_FAULT;
          default: begin
            // Unused codes (and RAMP when soft-start is not built) fall back to OFF.
            state      <= ST_OFF;
            npower     <= 1'b1;
            highz      <= 1'b1;
            latched    <= 1'b0;
            settle_cnt <= 16'd0;
          end
        endcase
      end
    end
  end

  assign bus.target_npower = npower;
  assign bus.target_highz  = highz;
  assign bus.pwr_state     = state;
  assign bus.fault_latched = latched;

endmodule
